// File: rtl/counter_pkg.sv
// Shared constants and types for the programmable counter.
// Direction and limit-mode encodings are also the pin encodings of dir/sat_mode.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Single action selected per cycle, in priority order clr > load > step.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_CLR  = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_STEP = 2'd3
  } cnt_action_e;

  function automatic cnt_action_e pick_action(input logic clr, input logic load,
                                              input logic step);
    cnt_action_e act;
    act = ACT_HOLD;
    if (clr)       act = ACT_CLR;
    else if (load) act = ACT_LOAD;
    else if (step) act = ACT_STEP;
    return act;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Enable prescaler: pulses tick combinationally on every (div+1)-th enabled cycle.
// restart drops any partial period so the next tick needs a full div+1 cycles.
module clk_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [PSC_W-1:0] div,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  // >= rather than == so that shrinking div below the current count ticks at once
  // instead of running the counter all the way round its field.
  always_comb begin
    tick      = 1'b0;
    psc_cnt_d = psc_cnt_q;
    if (restart) begin
      psc_cnt_d = '0;
    end else if (en) begin
      if (psc_cnt_q >= div) begin
        tick      = 1'b1;
        psc_cnt_d = '0;
      end else begin
        psc_cnt_d = psc_cnt_q + PSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc_cnt_q <= '0;
    else       psc_cnt_q <= psc_cnt_d;
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with runtime bound, wrap/saturate limit handling,
// prescaled stepping, terminal-count pulse and sticky overflow flag.
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] bound,
  input  logic             sat_mode,
  input  logic [PSC_W-1:0] psc_div,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             step;
  logic             psc_restart;
  logic             limit;
  logic [WIDTH-1:0] down_base;
  cnt_action_e      action;

  assign psc_restart = clr | load;

  clk_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (psc_restart),
    .div     (psc_div),
    .tick    (step)
  );

  assign action = pick_action(clr, load, step);

  // A value loaded above bound is pulled back to bound before counting down.
  assign down_base = (count_q > bound) ? bound : count_q;

  always_comb begin
    count_d = count_q;
    limit   = 1'b0;
    case (action)
      ACT_CLR:  count_d = '0;
      ACT_LOAD: count_d = load_val;
      ACT_STEP: begin
        if (dir == DIR_UP) begin
          if (count_q >= bound) begin
            limit   = 1'b1;
            count_d = (sat_mode == MODE_SAT) ? bound : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (down_base == '0) begin
            limit   = 1'b1;
            count_d = (sat_mode == MODE_SAT) ? '0 : bound;
          end else begin
            count_d = down_base - WIDTH'(1);
          end
        end
      end
      default:  count_d = count_q;
    endcase
  end

  // Setting ovf takes precedence over a coincident ovf_clr.
  always_comb begin
    tc_d  = limit;
    ovf_d = ovf_q;
    if (limit)        ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (WIDTH=8, PSC_W=4).
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_prog_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic [7:0] bound;
  logic       sat_mode;
  logic [3:0] psc_div;
  logic       ovf_clr;
  logic [7:0] count;
  logic       tc;
  logic       ovf;

  int tests;
  int fails;

  prog_counter #(
    .WIDTH (8),
    .PSC_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .bound    (bound),
    .sat_mode (sat_mode),
    .psc_div  (psc_div),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: count=%0d tc=%b ovf=%b, required 0/0/0", count, tc, ovf);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    edge1();
    tests++;
    if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: count=%0d tc=%b ovf=%b, required 0/0/0", count, tc, ovf);
    end
    $display("[TB] reset: count=%0d tc=%b ovf=%b", count, tc, ovf);
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_c;
    bound = 8'd9; dir = 1'b1; sat_mode = 1'b0; psc_div = 4'd0; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      edge1();
      exp_c = 8'(i % 10);
      tests++;
      if (count !== exp_c || tc !== (i == 10) || ovf !== (i >= 10)) begin
        fails++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b ovf=%b, required %0d/%b/%b",
                 i, count, tc, ovf, exp_c, (i == 10), (i >= 10));
      end
      $display("[TB] wrap_up cycle %0d: count=%0d tc=%b ovf=%b", i, count, tc, ovf);
    end
    en = 1'b0; ovf_clr = 1'b1;
    edge1();
    ovf_clr = 1'b0;
    tests++;
    if (ovf !== 1'b0 || count !== 8'd2) begin
      fails++;
      $display("FAIL ovf_clr: ovf=%b count=%0d, required 0/2", ovf, count);
    end
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    tests++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL clr: count=%0d tc=%b, required 0/0", count, tc);
    end
    $display("[TB] ovf_clr+clr: count=%0d ovf=%b", count, ovf);
  endtask

  task automatic test_sat_down();
    logic [7:0] exp_c [4];
    logic       exp_t [4];
    exp_c = '{8'd1, 8'd0, 8'd0, 8'd0};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
    bound = 8'd5; dir = 1'b0; sat_mode = 1'b1; psc_div = 4'd0;
    load_val = 8'd2; load = 1'b1; en = 1'b1;
    edge1();
    load = 1'b0;
    tests++;
    if (count !== 8'd2 || tc !== 1'b0) begin
      fails++;
      $display("FAIL sat_down_load: count=%0d tc=%b, required 2/0", count, tc);
    end
    for (int i = 0; i < 4; i++) begin
      edge1();
      tests++;
      if (count !== exp_c[i] || tc !== exp_t[i] || ovf !== exp_t[i]) begin
        fails++;
        $display("FAIL sat_down[%0d]: count=%0d tc=%b ovf=%b, required %0d/%b/%b",
                 i, count, tc, ovf, exp_c[i], exp_t[i], exp_t[i]);
      end
      $display("[TB] sat_down step %0d: count=%0d tc=%b ovf=%b", i, count, tc, ovf);
    end
    en = 1'b0;
    edge1();
    tests++;
    if (tc !== 1'b0 || count !== 8'd0 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_down_idle: tc=%b count=%0d ovf=%b, required 0/0/1", tc, count, ovf);
    end
  endtask

  task automatic test_prescale();
    logic [7:0] exp_c [16];
    exp_c = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
              8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
    bound = 8'd9; dir = 1'b1; sat_mode = 1'b0; psc_div = 4'd3;
    clr = 1'b1; ovf_clr = 1'b1; en = 1'b0;
    edge1();
    clr = 1'b0; ovf_clr = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      en = (k == 10 || k == 11) ? 1'b0 : 1'b1;
      edge1();
      tests++;
      if (count !== exp_c[k-1]) begin
        fails++;
        $display("FAIL prescale[%0d]: count=%0d, required %0d", k, count, exp_c[k-1]);
      end
      $display("[TB] prescale cycle %0d en=%b: count=%0d", k, en, count);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    psc_div = 4'd0; bound = 8'd9; dir = 1'b1; sat_mode = 1'b0;
    load_val = 8'd9; load = 1'b1; en = 1'b0;
    edge1();
    load = 1'b0; en = 1'b1;
    edge1();
    en = 1'b0; load_val = 8'd6; load = 1'b1;
    edge1();
    load = 1'b0;
    tests++;
    if (count !== 8'd6 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: count=%0d ovf=%b, required 6/1", count, ovf);
    end
    psc_div = 4'd3; en = 1'b1;
    edge1();
    edge1();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (count !== 8'd0 || ovf !== 1'b0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: count=%0d ovf=%b tc=%b, required 0/0/0", count, ovf, tc);
    end
    $display("[TB] async reset mid-count: count=%0d ovf=%b", count, ovf);
    load = 1'b1; load_val = 8'd7;
    edge1();
    tests++;
    if (count !== 8'd0) begin
      fails++;
      $display("FAIL reset_blocks_load: count=%0d, required 0", count);
    end
    load = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      edge1();
      tests++;
      if (count !== ((k == 4) ? 8'd1 : 8'd0)) begin
        fails++;
        $display("FAIL post_reset_psc[%0d]: count=%0d, required %0d",
                 k, count, (k == 4) ? 1 : 0);
      end
    end
    en = 1'b0; psc_div = 4'd0;
  endtask

  task automatic test_clr_load();
    en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 8'd7;
    edge1();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    tests++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL clr_over_load: count=%0d tc=%b, required 0/0", count, tc);
    end
    for (int m = 0; m < 2; m++) begin
      bound = 8'd50; dir = 1'b1; sat_mode = m[0];
      load_val = 8'd200; load = 1'b1;
      edge1();
      load = 1'b0;
      tests++;
      if (count !== 8'd200 || tc !== 1'b0) begin
        fails++;
        $display("FAIL load_above_bound[%0d]: count=%0d tc=%b, required 200/0", m, count, tc);
      end
      en = 1'b1;
      edge1();
      en = 1'b0;
      tests++;
      if (count !== ((m == 1) ? 8'd50 : 8'd0) || tc !== 1'b1) begin
        fails++;
        $display("FAIL above_bound_step[%0d]: count=%0d tc=%b, required %0d/1",
                 m, count, tc, (m == 1) ? 50 : 0);
      end
      $display("[TB] load 200 bound 50 sat=%0d step: count=%0d tc=%b", m, count, tc);
    end
    edge1();
    tests++;
    if (tc !== 1'b0) begin
      fails++;
      $display("FAIL tc_single_pulse: tc=%b, required 0", tc);
    end
  endtask

  task automatic test_ovf_set_wins();
    ovf_clr = 1'b1;
    edge1();
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr_alone: ovf=%b, required 0", ovf);
    end
    bound = 8'd3; dir = 1'b1; sat_mode = 1'b0; load_val = 8'd3; load = 1'b1; ovf_clr = 1'b0;
    edge1();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    edge1();
    tests++;
    if (ovf !== 1'b1 || count !== 8'd0 || tc !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: ovf=%b count=%0d tc=%b, required 1/0/1", ovf, count, tc);
    end
    edge1();
    en = 1'b0; ovf_clr = 1'b0;
    tests++;
    if (ovf !== 1'b0 || count !== 8'd1) begin
      fails++;
      $display("FAIL ovf_clr_after: ovf=%b count=%0d, required 0/1", ovf, count);
    end
    $display("[TB] ovf set vs clr: ovf=%b count=%0d", ovf, count);
  endtask

  task automatic test_bound_zero();
    bound = 8'd0; clr = 1'b1;
    edge1();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dir = i[1]; sat_mode = i[0]; en = 1'b1;
      edge1();
      tests++;
      if (count !== 8'd0 || tc !== 1'b1) begin
        fails++;
        $display("FAIL bound_zero[%0d]: count=%0d tc=%b, required 0/1", i, count, tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_runtime_change();
    bound = 8'd9; dir = 1'b1; sat_mode = 1'b0; load_val = 8'd5; load = 1'b1;
    edge1();
    load = 1'b0; en = 1'b1;
    edge1();
    tests++;
    if (count !== 8'd6) begin
      fails++;
      $display("FAIL change_up: count=%0d, required 6", count);
    end
    dir = 1'b0;
    edge1();
    edge1();
    tests++;
    if (count !== 8'd4) begin
      fails++;
      $display("FAIL change_dir: count=%0d, required 4", count);
    end
    bound = 8'd4; dir = 1'b1;
    edge1();
    en = 1'b0;
    tests++;
    if (count !== 8'd0 || tc !== 1'b1) begin
      fails++;
      $display("FAIL change_bound: count=%0d tc=%b, required 0/1", count, tc);
    end
    $display("[TB] runtime change: count=%0d tc=%b", count, tc);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
    dir = 1'b1; bound = 8'd9; sat_mode = 1'b0; psc_div = 4'd0; ovf_clr = 1'b0;

    test_reset();
    test_wrap_up();
    test_sat_down();
    test_prescale();
    test_async_reset();
    test_clr_load();
    test_ovf_set_wins();
    test_bound_zero();
    test_runtime_change();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
